// File: rtl/sr_bank_pkg.sv
// Shared constants and next-state helper for the SR storage bank.
// sr_next resolves one channel's next state from its current value and its s/r pair.
package sr_bank_pkg;
    localparam logic [1:0] CM_HOLD = 2'd0;
    localparam logic [1:0] CM_SET  = 2'd1;
    localparam logic [1:0] CM_RST  = 2'd2;
    localparam logic [1:0] CM_TOG  = 2'd3;

    function automatic logic sr_next(input logic [1:0] mode, input logic q,
                                     input logic s, input logic r);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                case (mode)
                    CM_SET:  nq = 1'b1;
                    CM_RST:  nq = 1'b0;
                    CM_TOG:  nq = ~q;
                    default: nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction
endpackage

// File: rtl/sr_latch_bank_if.sv
// Control/status bundle of the SR bank.
// The master modport drives control and the s/r vectors; the slave modport returns state and conflict status.
interface sr_latch_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             cnt_clr;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] conflict;
    logic             conflict_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (output en, clr, cnt_clr, s, r,
                    input  q, qb, conflict, conflict_sticky, conflict_cnt);
    modport slave  (input  en, clr, cnt_clr, s, r,
                    output q, qb, conflict, conflict_sticky, conflict_cnt);
endinterface

// File: rtl/sr_latch_bank_filter.sv
// Single-channel stability filter for one s/r pair.
// A pair is qualified once it has been sampled FILT_CYCLES+1 times in a row.
module sr_filter #(
    parameter int FILT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_s,
    input  logic i_r,
    output logic o_qual
);
    localparam int              SW  = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam logic [SW-1:0]   SAT = SW'(FILT_CYCLES);

    logic [1:0]    r_last;
    logic [SW-1:0] r_stab;
    logic [SW-1:0] w_stab_nxt;

    // Qualification looks at the count including the sample taken this edge.
    always_comb begin
        w_stab_nxt = '0;
        if ({i_s, i_r} == r_last)
            w_stab_nxt = (r_stab == SAT) ? SAT : r_stab + 1'b1;
    end

    assign o_qual = (w_stab_nxt == SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 2'b00;
            r_stab <= '0;
        end else if (i_clr) begin
            r_last <= 2'b00;
            r_stab <= '0;
        end else begin
            r_last <= {i_s, i_r};
            r_stab <= w_stab_nxt;
        end
    end
endmodule

// File: rtl/sr_latch_bank.sv
// Clocked bank of WIDTH set/reset flag cells with per-channel input filtering,
// selectable S=R=1 resolution and conflict reporting (pulse, sticky, saturating count).
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int unsigned      CONFLICT_MODE = 0,
    parameter int               FILT_CYCLES   = 0,
    parameter logic [WIDTH-1:0] RST_VAL       = '0,
    parameter int               CNT_W         = 8
) (
    input logic            clk,
    input logic            rst_n,
    sr_latch_bank_if.slave bus
);
    localparam logic [1:0] MODE = 2'(CONFLICT_MODE);

    logic [WIDTH-1:0] w_qual;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_conf_nxt;
    logic             w_any;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qb;
    logic [WIDTH-1:0] r_conf;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sr_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (bus.clr),
            .i_s    (bus.s[i]),
            .i_r    (bus.r[i]),
            .o_qual (w_qual[i])
        );
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_conf_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.en && w_qual[i]) begin
                w_q_nxt[i]    = sr_next(MODE, r_q[i], bus.s[i], bus.r[i]);
                w_conf_nxt[i] = bus.s[i] & bus.r[i];
            end
        end
        if (bus.clr) begin
            w_q_nxt    = RST_VAL;
            w_conf_nxt = '0;
        end
    end

    assign w_any = |w_conf_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= RST_VAL;
            r_qb   <= ~RST_VAL;
            r_conf <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_qb   <= ~w_q_nxt;
            r_conf <= w_conf_nxt;
        end
    end

    // A conflict landing on the same edge as cnt_clr survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (bus.cnt_clr) begin
            r_sticky <= w_any;
            r_cnt    <= w_any ? CNT_W'(1) : '0;
        end else if (w_any) begin
            r_sticky <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.q               = r_q;
    assign bus.qb              = r_qb;
    assign bus.conflict        = r_conf;
    assign bus.conflict_sticky = r_sticky;
    assign bus.conflict_cnt    = r_cnt;
endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench for sr_latch_bank across several parameter sets (reset value, filter, modes, counter width).
module tb_sr_latch_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    // A: RST_VAL A5, no filter; B: FILT_CYCLES 2; C: 2-bit counter
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(8)) ifa();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(8)) ifb();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(2)) ifc();

    sr_latch_bank #(.WIDTH(8), .CONFLICT_MODE(0), .FILT_CYCLES(0), .RST_VAL(8'hA5), .CNT_W(8))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    sr_latch_bank #(.WIDTH(8), .CONFLICT_MODE(0), .FILT_CYCLES(2), .RST_VAL(8'h00), .CNT_W(8))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    sr_latch_bank #(.WIDTH(8), .CONFLICT_MODE(0), .FILT_CYCLES(0), .RST_VAL(8'h00), .CNT_W(2))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    // One instance per CONFLICT_MODE, all driven by the same stimulus.
    logic       m_en, m_clr, m_cnt_clr;
    logic [7:0] m_s, m_r;
    logic [7:0] m_q[4];
    logic [7:0] m_conf[4];
    logic [7:0] m_cnt[4];
    logic       m_sticky[4];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_latch_bank_if #(.WIDTH(8), .CNT_W(8)) ifm();
        assign ifm.en      = m_en;
        assign ifm.clr     = m_clr;
        assign ifm.cnt_clr = m_cnt_clr;
        assign ifm.s       = m_s;
        assign ifm.r       = m_r;
        assign m_q[m]      = ifm.q;
        assign m_conf[m]   = ifm.conflict;
        assign m_cnt[m]    = ifm.conflict_cnt;
        assign m_sticky[m] = ifm.conflict_sticky;
        sr_latch_bank #(.WIDTH(8), .CONFLICT_MODE(m), .FILT_CYCLES(0), .RST_VAL(8'h00), .CNT_W(8))
            u_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
    end

    task automatic test_reset();
        ifa.en = 1'b1; ifa.clr = 1'b0; ifa.cnt_clr = 1'b0; ifa.s = '0; ifa.r = '0;
        ifb.en = 1'b1; ifb.clr = 1'b0; ifb.cnt_clr = 1'b0; ifb.s = '0; ifb.r = '0;
        ifc.en = 1'b1; ifc.clr = 1'b0; ifc.cnt_clr = 1'b0; ifc.s = '0; ifc.r = '0;
        m_en = 1'b1; m_clr = 1'b0; m_cnt_clr = 1'b0; m_s = '0; m_r = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (ifa.q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h expected a5", ifa.q); end
        checks++; if (ifa.qb !== 8'h5A) begin errors++; $display("FAIL reset_qb got %h expected 5a", ifa.qb); end
        checks++; if (ifa.conflict_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h expected 00", ifa.conflict_cnt); end
        checks++; if (ifa.conflict_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b expected 0", ifa.conflict_sticky); end
        checks++; if (ifa.conflict !== 8'h00) begin errors++; $display("FAIL reset_conflict got %h expected 00", ifa.conflict); end
        checks++; if (ifb.q !== 8'h00) begin errors++; $display("FAIL reset_q_b got %h expected 00", ifb.q); end
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_set();
        logic [7:0] s_t[4] = '{8'h01, 8'h02, 8'h00, 8'h00};
        logic [7:0] r_t[4] = '{8'h00, 8'h00, 8'h80, 8'h00};
        logic [7:0] q_t[4] = '{8'hA5, 8'hA7, 8'h27, 8'h27};
        logic [31:0] e;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            ifa.s = s_t[k]; ifa.r = r_t[k];
            sb_q.push_back({24'h0, q_t[k]});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifa.q !== e[7:0]) begin errors++; $display("FAIL set_q row%0d got %h expected %h", k, ifa.q, e[7:0]); end
            checks++; if (ifa.qb !== ~e[7:0]) begin errors++; $display("FAIL set_qb row%0d got %h expected %h", k, ifa.qb, ~e[7:0]); end
        end
    endtask

    task automatic test_filter();
        logic [7:0] s_t[7] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
        logic [7:0] q_t[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        logic [31:0] e;
        for (int k = 0; k < 7; k++) begin
            ifb.s = s_t[k];
            sb_q.push_back({24'h0, q_t[k]});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifb.q !== e[7:0]) begin errors++; $display("FAIL filter_q row%0d got %h expected %h", k, ifb.q, e[7:0]); end
        end
    endtask

    task automatic test_conflict_modes();
        logic [7:0] s_t[4] = '{8'h0F, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] r_t[4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] q_t[4][4] = '{'{8'h0F, 8'h0F, 8'h0F, 8'h0F},
                                  '{8'h0F, 8'hFF, 8'h00, 8'hF0},
                                  '{8'h0F, 8'hFF, 8'h00, 8'h0F},
                                  '{8'h0F, 8'hFF, 8'h00, 8'h0F}};
        logic [7:0] cf_t[4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] cn_t[4] = '{8'd0, 8'd1, 8'd2, 8'd2};
        logic       st_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] e;
        for (int k = 0; k < 4; k++) begin
            m_s = s_t[k]; m_r = r_t[k];
            for (int m = 0; m < 4; m++) begin
                sb_q.push_back({24'h0, q_t[k][m]});
                sb_q.push_back({24'h0, cf_t[k]});
                sb_q.push_back({24'h0, cn_t[k]});
                sb_q.push_back({31'h0, st_t[k]});
            end
            @(posedge clk); #1;
            for (int m = 0; m < 4; m++) begin
                e = sb_q.pop_front();
                checks++; if (m_q[m] !== e[7:0]) begin errors++; $display("FAIL mode%0d_q row%0d got %h expected %h", m, k, m_q[m], e[7:0]); end
                e = sb_q.pop_front();
                checks++; if (m_conf[m] !== e[7:0]) begin errors++; $display("FAIL mode%0d_conflict row%0d got %h expected %h", m, k, m_conf[m], e[7:0]); end
                e = sb_q.pop_front();
                checks++; if (m_cnt[m] !== e[7:0]) begin errors++; $display("FAIL mode%0d_cnt row%0d got %0d expected %0d", m, k, m_cnt[m], e[7:0]); end
                e = sb_q.pop_front();
                checks++; if (m_sticky[m] !== e[0]) begin errors++; $display("FAIL mode%0d_sticky row%0d got %b expected %b", m, k, m_sticky[m], e[0]); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] sr_t[8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        logic       cc_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] cn_t[8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0};
        logic       st_t[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] cf_t[8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        logic [31:0] e;
        for (int k = 0; k < 8; k++) begin
            ifc.s = sr_t[k]; ifc.r = sr_t[k]; ifc.cnt_clr = cc_t[k];
            sb_q.push_back({30'h0, cn_t[k]});
            sb_q.push_back({31'h0, st_t[k]});
            sb_q.push_back({24'h0, cf_t[k]});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifc.conflict_cnt !== e[1:0]) begin errors++; $display("FAIL sat_cnt row%0d got %0d expected %0d", k, ifc.conflict_cnt, e[1:0]); end
            e = sb_q.pop_front();
            checks++; if (ifc.conflict_sticky !== e[0]) begin errors++; $display("FAIL sat_sticky row%0d got %b expected %b", k, ifc.conflict_sticky, e[0]); end
            e = sb_q.pop_front();
            checks++; if (ifc.conflict !== e[7:0]) begin errors++; $display("FAIL sat_conflict row%0d got %h expected %h", k, ifc.conflict, e[7:0]); end
        end
        ifc.cnt_clr = 1'b0;
    endtask

    task automatic test_en_clr();
        logic       en_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       clr_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] s_t[5]   = '{8'h08, 8'h08, 8'h01, 8'hFF, 8'h00};
        logic [7:0] r_t[5]   = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'h00};
        logic [7:0] q_t[5]   = '{8'h27, 8'h2F, 8'h2F, 8'hA5, 8'hA5};
        logic [31:0] e;
        for (int k = 0; k < 5; k++) begin
            ifa.en = en_t[k]; ifa.clr = clr_t[k]; ifa.s = s_t[k]; ifa.r = r_t[k];
            sb_q.push_back({24'h0, q_t[k]});
            sb_q.push_back(32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifa.q !== e[7:0]) begin errors++; $display("FAIL enclr_q row%0d got %h expected %h", k, ifa.q, e[7:0]); end
            e = sb_q.pop_front();
            checks++; if (ifa.conflict !== e[7:0]) begin errors++; $display("FAIL enclr_conflict row%0d got %h expected %h", k, ifa.conflict, e[7:0]); end
        end
        checks++; if (ifa.conflict_cnt !== 8'h00) begin errors++; $display("FAIL enclr_cnt got %0d expected 0", ifa.conflict_cnt); end
        checks++; if (ifa.conflict_sticky !== 1'b0) begin errors++; $display("FAIL enclr_sticky got %b expected 0", ifa.conflict_sticky); end
    endtask

    task automatic test_async_reset();
        logic [7:0] q_t[3] = '{8'h00, 8'h00, 8'h02};
        logic [31:0] e;
        ifb.s = 8'h02;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(32'h01);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifb.q !== e[7:0]) begin errors++; $display("FAIL midfilt_q row%0d got %h expected %h", k, ifb.q, e[7:0]); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifb.q !== 8'h00) begin errors++; $display("FAIL async_q got %h expected 00", ifb.q); end
        checks++; if (ifb.qb !== 8'hFF) begin errors++; $display("FAIL async_qb got %h expected ff", ifb.qb); end
        checks++; if (ifa.q !== 8'hA5) begin errors++; $display("FAIL async_q_a got %h expected a5", ifa.q); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back({24'h0, q_t[k]});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            checks++; if (ifb.q !== e[7:0]) begin errors++; $display("FAIL postrst_q row%0d got %h expected %h", k, ifb.q, e[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_filter();
        test_conflict_modes();
        test_saturate();
        test_en_clr();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d expected 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
